// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 mouse receive path.
// Holds the bit-level FSM state enum, status-byte bit positions,
// the frame length and a helper that clamps a signed sum into 0..vmax.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  // Status byte (packet byte 0) bit positions
  localparam int BIT_L    = 0;
  localparam int BIT_R    = 1;
  localparam int BIT_M    = 2;
  localparam int BIT_SYNC = 3;
  localparam int BIT_XS   = 4;
  localparam int BIT_YS   = 5;
  localparam int BIT_XO   = 6;
  localparam int BIT_YO   = 7;

  // start + 8 data + parity + stop
  localparam int FRAME_LEN = 11;

  // Clamp a 14-bit signed position into [0, vmax].
  function automatic logic [11:0] clamp_pos(input logic signed [13:0] v,
                                            input logic [11:0] vmax);
    logic signed [13:0] w_max;
    w_max = $signed({2'b00, vmax});
    if (v < 14'sd0)
      return 12'd0;
    else if (v > w_max)
      return vmax;
    else
      return v[11:0];
  endfunction

endpackage

// File: rtl/ps2_rx_byte.sv
// PS/2 device-to-host byte receiver: synchronises ps2_clk/ps2_data, detects
// falling edges, deserialises 11-bit frames and checks odd parity and stop bit.
// Ports: i_clk/i_rst (sync, active-high), i_ps2_clk/i_ps2_data raw lines,
//   i_pkt_idle (packet assembler at byte index 0), o_byte_vld/o_byte_dat good
//   byte pulse, o_err bad parity/stop pulse, o_abort inactivity timeout pulse.
module ps2_rx_byte import ps2_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 65000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  input  logic       i_pkt_idle,
  output logic       o_byte_vld,
  output logic [7:0] o_byte_dat,
  output logic       o_err,
  output logic       o_abort
);

  localparam int CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DATA_BITS = FRAME_LEN - 3;

  logic             r_clk_s1, r_clk_s2, r_clk_prev;
  logic             r_dat_s1, r_dat_s2;
  rx_state_t        r_state;
  logic [7:0]       r_shift;
  logic [2:0]       r_bitcnt;
  logic             r_parity;
  logic [CNT_W-1:0] r_cnt;

  logic w_fall, w_dat, w_par_ok, w_idle_clr, w_timeout;

  // Lines idle high; resetting the stages to 1 avoids a false edge out of reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1   <= i_ps2_clk;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= i_ps2_data;
      r_dat_s2   <= r_dat_s1;
    end
  end

  assign w_fall     = r_clk_prev & ~r_clk_s2;
  assign w_dat      = r_dat_s2;
  assign w_par_ok   = ^{r_shift, r_parity};
  // Nothing in flight: neither a frame nor a partial packet.
  assign w_idle_clr = (r_state == IDLE) && i_pkt_idle;
  assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_shift  <= 8'd0;
      r_bitcnt <= 3'd0;
      r_parity <= 1'b0;
      r_cnt    <= '0;
    end else if (w_fall) begin
      // An edge always beats a coincident timeout.
      r_cnt <= '0;
      case (r_state)
        IDLE: begin
          if (!w_dat) begin
            r_state  <= DATA;
            r_bitcnt <= 3'd0;
          end
        end
        DATA: begin
          r_shift  <= {w_dat, r_shift[7:1]};
          r_bitcnt <= r_bitcnt + 3'd1;
          if (r_bitcnt == 3'(DATA_BITS - 1))
            r_state <= PARITY;
        end
        PARITY: begin
          r_parity <= w_dat;
          r_state  <= STOP;
        end
        STOP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end else if (w_idle_clr) begin
      r_cnt <= '0;
    end else if (w_timeout) begin
      r_cnt   <= '0;
      r_state <= IDLE;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Pulses are decoded from registered state so the top can register them
  // on the very next edge.
  assign o_byte_vld = w_fall && (r_state == STOP) && w_par_ok && w_dat;
  assign o_err      = w_fall && (r_state == STOP) && !(w_par_ok && w_dat);
  assign o_abort    = !w_fall && !w_idle_clr && w_timeout;
  assign o_byte_dat = r_shift;

endmodule

// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse receiver: assembles 3-byte movement packets into a clamped
// absolute cursor position and button levels.
// Ports: clk/rst (sync, active-high), ps2_clk/ps2_data raw lines, xpos/ypos
//   cursor, left/right/middle_mouse levels, new_event and frame_err pulses.
module ps2_mouse_rx import ps2_pkg::*; #(
  parameter int XMAX           = 1023,
  parameter int YMAX           = 767,
  parameter int X_INIT         = 512,
  parameter int Y_INIT         = 384,
  parameter int TIMEOUT_CYCLES = 65000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        left_mouse,
  output logic        right_mouse,
  output logic        middle_mouse,
  output logic        new_event,
  output logic        frame_err
);

  logic       w_byte_vld, w_err, w_abort;
  logic [7:0] w_byte;

  logic [1:0]  r_idx;
  logic [2:0]  r_btn;       // {M, R, L} from the status byte
  logic        r_xs, r_ys, r_xo, r_yo;
  logic [7:0]  r_dx;
  logic [11:0] r_xpos, r_ypos;
  logic        r_left, r_right, r_middle;
  logic        r_new_event, r_frame_err;

  logic signed [13:0] w_dx, w_dy, w_xsum, w_ysum;

  ps2_rx_byte #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx_byte (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_ps2_clk  (ps2_clk),
    .i_ps2_data (ps2_data),
    .i_pkt_idle (r_idx == 2'd0),
    .o_byte_vld (w_byte_vld),
    .o_byte_dat (w_byte),
    .o_err      (w_err),
    .o_abort    (w_abort)
  );

  // Deltas are 9-bit two's complement sign-extended to 14 bits; an overflow
  // flag zeroes the delta. dy comes straight from the byte being completed.
  always_comb begin
    w_dx = 14'sd0;
    w_dy = 14'sd0;
    if (!r_xo)
      w_dx = {{5{r_xs}}, r_xs, r_dx};
    if (!r_yo)
      w_dy = {{5{r_ys}}, r_ys, w_byte};
    w_xsum = $signed({2'b00, r_xpos}) + w_dx;
    // Screen Y grows downward while PS/2 +Y means up.
    w_ysum = $signed({2'b00, r_ypos}) - w_dy;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx       <= 2'd0;
      r_btn       <= 3'd0;
      r_xs        <= 1'b0;
      r_ys        <= 1'b0;
      r_xo        <= 1'b0;
      r_yo        <= 1'b0;
      r_dx        <= 8'd0;
      r_xpos      <= 12'(X_INIT);
      r_ypos      <= 12'(Y_INIT);
      r_left      <= 1'b0;
      r_right     <= 1'b0;
      r_middle    <= 1'b0;
      r_new_event <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_new_event <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_err || w_abort) begin
        r_idx       <= 2'd0;
        r_frame_err <= 1'b1;
      end else if (w_byte_vld) begin
        case (r_idx)
          2'd0: begin
            // A clear sync bit means we are misaligned: drop the byte and
            // keep hunting for a status byte.
            if (w_byte[BIT_SYNC]) begin
              r_btn <= {w_byte[BIT_M], w_byte[BIT_R], w_byte[BIT_L]};
              r_xs  <= w_byte[BIT_XS];
              r_ys  <= w_byte[BIT_YS];
              r_xo  <= w_byte[BIT_XO];
              r_yo  <= w_byte[BIT_YO];
              r_idx <= 2'd1;
            end else begin
              r_frame_err <= 1'b1;
            end
          end
          2'd1: begin
            r_dx  <= w_byte;
            r_idx <= 2'd2;
          end
          default: begin
            r_xpos      <= clamp_pos(w_xsum, 12'(XMAX));
            r_ypos      <= clamp_pos(w_ysum, 12'(YMAX));
            r_left      <= r_btn[0];
            r_right     <= r_btn[1];
            r_middle    <= r_btn[2];
            r_new_event <= 1'b1;
            r_idx       <= 2'd0;
          end
        endcase
      end
    end
  end

  assign xpos         = r_xpos;
  assign ypos         = r_ypos;
  assign left_mouse   = r_left;
  assign right_mouse  = r_right;
  assign middle_mouse = r_middle;
  assign new_event    = r_new_event;
  assign frame_err    = r_frame_err;

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Scoreboard bench for ps2_mouse_rx: directed PS/2 frames are driven while the
// expected output snapshot for each new_event/frame_err pulse is queued; a
// monitor pops and compares on every pulse.
module tb_ps2_mouse_rx;
  import ps2_pkg::*;

  localparam int TIMEOUT_CYCLES = 65000;
  localparam int HALF           = 6;   // clk cycles per PS/2 half period
  localparam int GAP            = 20;  // idle clk cycles between bytes

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [11:0] xpos, ypos;
  logic        left_mouse, right_mouse, middle_mouse;
  logic        new_event, frame_err;

  ps2_mouse_rx dut (
    .clk          (clk),
    .rst          (rst),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .xpos         (xpos),
    .ypos         (ypos),
    .left_mouse   (left_mouse),
    .right_mouse  (right_mouse),
    .middle_mouse (middle_mouse),
    .new_event    (new_event),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        kind;   // 0 = new_event, 1 = frame_err
    logic [11:0] x;
    logic [11:0] y;
    logic        l, r, m;
  } exp_t;

  exp_t q[$];
  int   compared   = 0;
  int   mismatched = 0;
  logic prev_pulse = 1'b0;
  exp_t act, e;

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (prev_pulse) begin
        compared++;
        if (new_event || frame_err) begin
          mismatched++;
          $display("FAIL pulse_width: pulse still high next cycle (new_event=%0d frame_err=%0d), required both 0",
                   new_event, frame_err);
        end
      end
      prev_pulse = new_event | frame_err;
      if (new_event || frame_err) begin
        act = {frame_err, xpos, ypos, left_mouse, right_mouse, middle_mouse};
        compared++;
        if (q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_pulse: got kind=%0d x=%0d y=%0d lrm=%b%b%b, required no pulse",
                   act.kind, act.x, act.y, act.l, act.r, act.m);
        end else begin
          e = q.pop_front();
          if (act != e) begin
            mismatched++;
            $display("FAIL pkt_out: got kind=%0d x=%0d y=%0d lrm=%b%b%b, required kind=%0d x=%0d y=%0d lrm=%b%b%b",
                     act.kind, act.x, act.y, act.l, act.r, act.m,
                     e.kind, e.x, e.y, e.l, e.r, e.m);
          end
        end
      end
    end
  end

  // Watchdog
  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog expired");
  end

  task automatic exp_push(input logic kind, input int x, input int y,
                          input logic l, input logic r, input logic m);
    exp_t t;
    t = {kind, 12'(x), 12'(y), l, r, m};
    q.push_back(t);
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(1'b1);
    repeat (GAP) @(posedge clk);
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0, 1'b0);
    send_byte(b1, 1'b0);
    send_byte(b2, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst      = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic check_reset(input string name);
    logic [30:0] got;
    logic [30:0] req;
    @(negedge clk);
    got = {xpos, ypos, left_mouse, right_mouse, middle_mouse, new_event, frame_err};
    req = {12'd512, 12'd384, 3'b000, 2'b00};
    compared++;
    if (got != req) begin
      mismatched++;
      $display("FAIL %s: got x=%0d y=%0d lrm=%b%b%b ev=%b err=%b, required x=512 y=384 lrm=000 ev=0 err=0",
               name, xpos, ypos, left_mouse, right_mouse, middle_mouse, new_event, frame_err);
    end
  endtask

  // Bounded wait for all queued pulses, then a quiet window for stray ones.
  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    repeat (60) @(posedge clk);
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL %s: %0d expected pulses never seen, required 0 outstanding", name, q.size());
      q.delete();
    end
  endtask

  initial begin
    // Reset state
    do_reset();
    check_reset("reset_state");

    // Left button, +16 right, +5 up
    exp_push(1'b0, 528, 379, 1'b1, 1'b0, 1'b0);
    send_pkt(8'h09, 8'h10, 8'h05);
    drain("pkt_basic");

    // dx = -256 three times: clamps at 0
    do_reset();
    check_reset("reset_2");
    exp_push(1'b0, 256, 384, 1'b0, 1'b0, 1'b0);
    exp_push(1'b0, 0,   384, 1'b0, 1'b0, 1'b0);
    exp_push(1'b0, 0,   384, 1'b0, 1'b0, 1'b0);
    send_pkt(8'h18, 8'h00, 8'h00);
    send_pkt(8'h18, 8'h00, 8'h00);
    send_pkt(8'h18, 8'h00, 8'h00);
    drain("pkt_clamp_x");

    // Bad parity on byte 1, then a clean packet with dy = +255
    do_reset();
    exp_push(1'b1, 512, 384, 1'b0, 1'b0, 1'b0);
    send_byte(8'h09, 1'b0);
    send_byte(8'h10, 1'b1);
    exp_push(1'b0, 513, 129, 1'b0, 1'b1, 1'b0);
    send_pkt(8'h0A, 8'h01, 8'hFF);
    drain("pkt_parity");

    // Stray byte without sync bit, then a middle-button packet
    do_reset();
    exp_push(1'b1, 512, 384, 1'b0, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0);
    exp_push(1'b0, 514, 384, 1'b0, 1'b0, 1'b1);
    send_pkt(8'h0C, 8'h02, 8'h00);
    drain("pkt_resync");

    // Reset mid-frame: no pulse afterwards
    do_reset();
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    do_reset();
    check_reset("reset_midframe");
    drain("midframe_quiet");

    // Stalled ps2_clk after 5 data bits -> one timeout error
    exp_push(1'b1, 512, 384, 1'b0, 1'b0, 1'b0);
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(1'b1);
    repeat (TIMEOUT_CYCLES + 2) @(posedge clk);
    drain("timeout");

    // X overflow forces dx to 0
    exp_push(1'b0, 512, 384, 1'b0, 1'b0, 1'b0);
    send_pkt(8'h48, 8'h50, 8'h00);
    drain("pkt_xovf");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
